// File: rtl/memory_arbiter.sv
// Memory arbiter: one shared memory port serving instruction fetch and data load/store.
// Define MEM_ARB_TIMEOUT_EN to abort transactions stuck on mem_busy after TIMEOUT_CYCLES.
module memory_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemRen,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        i_ready,
    input  logic        dmmRen,
    input  logic        dmmWen,
    input  logic [31:0] dmmaddr,
    input  logic [31:0] dmmstore,
    input  logic [1:0]  d_fetch,
    output logic [31:0] dmmload,
    output logic        d_ready,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sel,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    output logic        arb_err
);

    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [31:0] ABORT_WORD = 32'hDEAD_BEEF;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, DREQ, IREQ, DONE} state_e;

    state_e             state_q, state_d;
    logic               last_data_q, last_data_d;
    logic               is_wr_q, is_wr_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_ren_q, mem_ren_d;
    logic               mem_wen_q, mem_wen_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_sel_q, mem_sel_d;
    logic               i_ready_q, i_ready_d;
    logic               d_ready_q, d_ready_d;
    logic [31:0]        imemload_q, imemload_d;
    logic [31:0]        dmmload_q, dmmload_d;
    logic               err_q, err_d;

    logic               d_win_c;
    logic [3:0]         d_sel_c;
    logic [31:0]        d_wdata_c;
    logic [31:0]        lane_c;
    logic               timeout_c;

`ifdef MEM_ARB_TIMEOUT_EN
    assign timeout_c = mem_busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Data wins a tie unless the last completed transaction was data.
    assign d_win_c = (dmmRen || dmmWen) && (!imemRen || !last_data_q);

    // Byte enables and lane-shifted store data for the incoming data request.
    always_comb begin
        d_sel_c   = 4'b1111;
        d_wdata_c = dmmstore;
        case (d_fetch)
            2'b00: begin
                d_sel_c   = 4'b0001 << dmmaddr[1:0];
                d_wdata_c = dmmstore << {dmmaddr[1:0], 3'b000};
            end
            2'b01: begin
                d_sel_c   = 4'b0011 << {dmmaddr[1], 1'b0};
                d_wdata_c = dmmstore << {dmmaddr[1], 4'b0000};
            end
            default: ;
        endcase
    end

    // Right-aligned, zero-extended load lane from the latched offset/size.
    always_comb begin
        lane_c = mem_rdata;
        case (size_q)
            2'b00:   lane_c = (mem_rdata >> {off_q, 3'b000}) & 32'h0000_00FF;
            2'b01:   lane_c = (mem_rdata >> {off_q[1], 4'b0000}) & 32'h0000_FFFF;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        is_wr_d     = is_wr_q;
        off_d       = off_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_sel_d   = mem_sel_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        imemload_d  = imemload_q;
        dmmload_d   = dmmload_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (d_win_c) begin
                    state_d     = DREQ;
                    is_wr_d     = dmmWen;
                    mem_wen_d   = dmmWen;
                    mem_ren_d   = !dmmWen;
                    mem_addr_d  = dmmaddr & WORD_MASK;
                    mem_sel_d   = d_sel_c;
                    mem_wdata_d = d_wdata_c;
                    off_d       = dmmaddr[1:0];
                    size_d      = d_fetch;
                end else if (imemRen) begin
                    state_d    = IREQ;
                    mem_ren_d  = 1'b1;
                    mem_wen_d  = 1'b0;
                    mem_addr_d = imemaddr & WORD_MASK;
                    mem_sel_d  = 4'b1111;
                end
            end
            DREQ, IREQ: begin
                if (!mem_busy || timeout_c) begin
                    state_d     = DONE;
                    mem_ren_d   = 1'b0;
                    mem_wen_d   = 1'b0;
                    cnt_d       = '0;
                    last_data_d = (state_q == DREQ);
                    err_d       = err_q | timeout_c;
                    if (state_q == IREQ) begin
                        i_ready_d  = 1'b1;
                        imemload_d = timeout_c ? ABORT_WORD : mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!is_wr_q) begin
                            dmmload_d = timeout_c ? ABORT_WORD : lane_c;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            is_wr_q     <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            cnt_q       <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_sel_q   <= 4'h0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            imemload_q  <= 32'h0;
            dmmload_q   <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            is_wr_q     <= is_wr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_sel_q   <= mem_sel_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            imemload_q  <= imemload_d;
            dmmload_q   <= dmmload_d;
            err_q       <= err_d;
        end
    end

    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_sel   = mem_sel_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign imemload  = imemload_q;
    assign dmmload   = dmmload_q;
    assign arb_err   = err_q;

endmodule
